// File: rtl/status_bar_engine.sv
// rtl/status_bar_engine.sv - status bar: BCD countdown timer, hearts, timer/level digits over a background band
// Purpose: owns an N-digit BCD countdown (load/add/pause/expiry), blink and heart-loss animation,
//          and renders one registered drawingRequest/RGB pair for the top-level priority mux.
// Ports:   clk, resetN (async, active-low)
//          startOfFrame, sec_tick                 - frame / second strobes
//          timer_load, load_value                 - load countdown (BCD)
//          add_valid, add_value                   - add BCD seconds (saturating)
//          pause                                  - level, freezes countdown
//          pixelX, pixelY                         - current pixel
//          num_of_hearts, level_num               - lives remaining, BCD level
//          timer, timer_running, out_of_time, warn - registered timer status
//          barDrawingRequest, barRGB              - registered pixel output (1 clk latency)
module status_bar_engine #(
    parameter int         TIMER_DIGITS = 2,
    parameter int         LEVEL_DIGITS = 2,
    parameter int         MAX_HEARTS   = 3,
    parameter int         BAR_HEIGHT   = 48,
    parameter int         WARN_SECONDS = 5,
    parameter int         BLINK_FRAMES = 15,
    parameter int         LOSS_FRAMES  = 60,
    parameter logic [7:0] BG_COLOR     = 8'h49,
    parameter logic [7:0] DIGIT_COLOR  = 8'hFF,
    localparam int        TW           = TIMER_DIGITS * 4,
    localparam int        HW           = $clog2(MAX_HEARTS + 1)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    sec_tick,
    input  logic                    timer_load,
    input  logic [TW-1:0]           load_value,
    input  logic                    add_valid,
    input  logic [TW-1:0]           add_value,
    input  logic                    pause,
    input  logic [10:0]             pixelX,
    input  logic [10:0]             pixelY,
    input  logic [HW-1:0]           num_of_hearts,
    input  logic [LEVEL_DIGITS*4-1:0] level_num,
    output logic [TW-1:0]           timer,
    output logic                    timer_running,
    output logic                    out_of_time,
    output logic                    warn,
    output logic                    barDrawingRequest,
    output logic [7:0]              barRGB
);
    localparam logic [7:0] HEART_COLOR = 8'hE0;
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int LCW = $clog2(LOSS_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
    state_t          state, state_n;
    logic [TW-1:0]   timer_n;
    logic            oot_n;

    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          borrow;
        r = v;
        borrow = 1'b1;
        for (int k = 0; k < TIMER_DIGITS; k++) begin
            if (borrow) begin
                if (r[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = r[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] bcd_add_sat(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW-1:0] r;
        logic [4:0]    s;
        logic          c;
        r = '0;
        c = 1'b0;
        for (int k = 0; k < TIMER_DIGITS; k++) begin
            s = {1'b0, a[4*k +: 4]} + {1'b0, b[4*k +: 4]} + {4'd0, c};
            c = (s > 5'd9);
            if (c) s = s - 5'd10;
            r[4*k +: 4] = s[3:0];
        end
        if (c) r = {TIMER_DIGITS{4'h9}};
        return r;
    endfunction

    function automatic logic [13:0] bcd_to_bin(input logic [TW-1:0] v);
        logic [13:0] r;
        r = '0;
        for (int k = TIMER_DIGITS - 1; k >= 0; k--) r = r * 14'd10 + {10'd0, v[4*k +: 4]};
        return r;
    endfunction

    // Seven-segment glyph in a 16x32 cell; 4'hF renders the level marker "F", 10..14 are blank.
    function automatic logic glyph_pixel(input logic [3:0] g, input logic [3:0] lx, input logic [4:0] ly);
        logic [6:0] s;  // {a,b,c,d,e,f,g}
        case (g)
            4'd0: s = 7'b1111110;  4'd1: s = 7'b0110000;
            4'd2: s = 7'b1101101;  4'd3: s = 7'b1111001;
            4'd4: s = 7'b0110011;  4'd5: s = 7'b1011011;
            4'd6: s = 7'b1011111;  4'd7: s = 7'b1110000;
            4'd8: s = 7'b1111111;  4'd9: s = 7'b1111011;
            4'hF: s = 7'b1000111;  default: s = 7'b0000000;
        endcase
        return (s[6] && ly <= 5'd5) ||
               (s[5] && lx >= 4'd10 && ly <= 5'd15) ||
               (s[4] && lx >= 4'd10 && ly >= 5'd16) ||
               (s[3] && ly >= 5'd26) ||
               (s[2] && lx <= 4'd5 && ly >= 5'd16) ||
               (s[1] && lx <= 4'd5 && ly <= 5'd15) ||
               (s[0] && ly >= 5'd13 && ly <= 5'd18);
    endfunction

    // Timer FSM: load beats add, add beats tick.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        oot_n   = out_of_time;
        if (timer_load) begin
            timer_n = load_value;
            oot_n   = 1'b0;
            if (load_value == '0) state_n = EXPIRED;
            else if (pause)       state_n = PAUSED;
            else                  state_n = RUN;
        end else begin
            if (state == RUN || state == PAUSED) state_n = pause ? PAUSED : RUN;
            if (add_valid && (state == RUN || state == PAUSED)) begin
                timer_n = bcd_add_sat(timer, add_value);
            end else if (sec_tick && state == RUN) begin
                timer_n = bcd_dec(timer);
                if (timer == TW'(1)) begin
                    state_n = EXPIRED;
                    oot_n   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timer         <= '0;
            out_of_time   <= 1'b0;
            timer_running <= 1'b0;
            warn          <= 1'b0;
        end else begin
            timer         <= timer_n;
            out_of_time   <= oot_n;
            timer_running <= (state_n == RUN);
            warn          <= (state_n == RUN || state_n == PAUSED) && (bcd_to_bin(timer_n) <= 14'(WARN_SECONDS));
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frames, starts visible.
    logic [FCW-1:0] frame_cnt;
    logic           blink_phase;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (startOfFrame) begin
            if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Hearts and loss animation. loss_mask_n feeds the pixel path so a lost heart never drops out for a cycle.
    logic [HW-1:0]         hearts, prev_hearts;
    logic [MAX_HEARTS-1:0] active, prev_active, loss_mask, loss_mask_n;
    logic [LCW-1:0]        loss_cnt, loss_cnt_n;

    assign hearts = (int'(num_of_hearts) > MAX_HEARTS) ? HW'(MAX_HEARTS) : num_of_hearts;

    always_comb begin
        active      = '0;
        prev_active = '0;
        for (int i = 0; i < MAX_HEARTS; i++) begin
            active[i]      = (HW'(i) < hearts);
            prev_active[i] = (HW'(i) < prev_hearts);
        end
        loss_mask_n = loss_mask & ~active;
        loss_cnt_n  = loss_cnt;
        if (hearts < prev_hearts) begin
            loss_mask_n = (loss_mask | prev_active) & ~active;
            loss_cnt_n  = LCW'(LOSS_FRAMES);
        end else if (startOfFrame && loss_mask_n != '0) begin
            if (loss_cnt <= LCW'(1)) begin
                loss_mask_n = '0;
                loss_cnt_n  = '0;
            end else begin
                loss_cnt_n = loss_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_hearts <= '0;
            loss_mask   <= '0;
            loss_cnt    <= '0;
        end else begin
            prev_hearts <= hearts;
            loss_mask   <= loss_mask_n;
            loss_cnt    <= loss_cnt_n;
        end
    end

    // Pixel path
    logic       in_band, in_row, heart_hit, digit_hit, timer_visible;
    logic [4:0] dy;

    always_comb begin
        in_band       = (pixelX < 11'd640) && (pixelY < 11'(BAR_HEIGHT));
        in_row        = (pixelY >= 11'd8) && (pixelY < 11'd40);
        dy            = 5'(pixelY - 11'd8);
        timer_visible = !(warn && !blink_phase);
        heart_hit     = 1'b0;
        digit_hit     = 1'b0;
        for (int i = 0; i < MAX_HEARTS; i++) begin
            if (in_row && pixelX >= 11'(16 + 48*i) && pixelX < 11'(48 + 48*i) &&
                (active[i] || (loss_mask_n[i] && blink_phase)))
                heart_hit = 1'b1;
        end
        for (int k = 0; k < TIMER_DIGITS; k++) begin
            if (in_row && timer_visible && pixelX >= 11'(320 - 24*k) && pixelX < 11'(336 - 24*k) &&
                glyph_pixel(timer[4*k +: 4], 4'(pixelX - 11'(320 - 24*k)), dy))
                digit_hit = 1'b1;
        end
        for (int k = 0; k < LEVEL_DIGITS; k++) begin
            if (in_row && pixelX >= 11'(608 - 24*k) && pixelX < 11'(624 - 24*k) &&
                glyph_pixel(level_num[4*k +: 4], 4'(pixelX - 11'(608 - 24*k)), dy))
                digit_hit = 1'b1;
        end
        if (in_row && pixelX >= 11'(608 - 24*LEVEL_DIGITS) && pixelX < 11'(624 - 24*LEVEL_DIGITS) &&
            glyph_pixel(4'hF, 4'(pixelX - 11'(608 - 24*LEVEL_DIGITS)), dy))
            digit_hit = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            barDrawingRequest <= 1'b0;
            barRGB            <= 8'h00;
        end else begin
            barDrawingRequest <= in_band;
            if (!in_band)       barRGB <= 8'h00;
            else if (heart_hit) barRGB <= HEART_COLOR;
            else if (digit_hit) barRGB <= DIGIT_COLOR;
            else                barRGB <= BG_COLOR;
        end
    end
endmodule

// File: tb/tb_status_bar_engine.sv
// tb/tb_status_bar_engine.sv - self-checking bench for status_bar_engine against a behavioural model
module tb_status_bar_engine;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAU = 2, S_EXP = 3;

    logic        clk = 1'b0, resetN = 1'b1;
    logic        startOfFrame = 1'b0, sec_tick = 1'b0, timer_load = 1'b0, add_valid = 1'b0, pause = 1'b0;
    logic [7:0]  load_value = 8'h00, add_value = 8'h00, level_num = 8'h07;
    logic [10:0] pixelX = 11'd0, pixelY = 11'd0;
    logic [1:0]  num_of_hearts = 2'd3;
    logic [7:0]  timer, barRGB;
    logic        timer_running, out_of_time, warn, barDrawingRequest;

    status_bar_engine dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .sec_tick(sec_tick),
        .timer_load(timer_load), .load_value(load_value), .add_valid(add_valid), .add_value(add_value),
        .pause(pause), .pixelX(pixelX), .pixelY(pixelY), .num_of_hearts(num_of_hearts),
        .level_num(level_num), .timer(timer), .timer_running(timer_running), .out_of_time(out_of_time),
        .warn(warn), .barDrawingRequest(barDrawingRequest), .barRGB(barRGB)
    );

    always #5 clk = ~clk;

    // Reference model: timer as a plain integer of seconds, blink from a running frame count.
    int       m_val, m_st, m_frames, m_prevh, m_left;
    bit       m_oot, m_warn;
    bit [2:0] m_lost;
    int       n_checks = 0, n_fail = 0;

    string seg_of [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "", "", "", "", "", "aefg"};
    int rx0 [7] = '{0, 10, 10, 0, 0, 0, 0};
    int rx1 [7] = '{15, 15, 15, 15, 5, 5, 15};
    int ry0 [7] = '{0, 0, 16, 26, 16, 0, 13};
    int ry1 [7] = '{5, 15, 31, 31, 31, 15, 18};

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic bit phase();
        return ((m_frames / 15) % 2) == 0;
    endfunction

    function automatic bit glyph_on(input int g, input int lx, input int ly);
        string s;
        int    sg;
        s = seg_of[g];
        for (int i = 0; i < s.len(); i++) begin
            sg = int'(s[i]) - 97;
            if (lx >= rx0[sg] && lx <= rx1[sg] && ly >= ry0[sg] && ly <= ry1[sg]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Returns {request, rgb} expected one clock after (px,py) is presented.
    function automatic logic [8:0] model_pixel(input int px, input int py, input int h, input bit [2:0] lost);
        bit ph, heart, dig;
        int x0, g;
        if (px >= 640 || py >= 48) return 9'h000;
        ph = phase();
        heart = 1'b0;
        dig = 1'b0;
        if (py >= 8 && py < 40) begin
            for (int i = 0; i < 3; i++)
                if (px >= 16 + 48*i && px < 48 + 48*i && (i < h || (lost[i] && ph))) heart = 1'b1;
            for (int k = 0; k < 2; k++) begin
                x0 = 320 - 24*k;
                g = (int'(int2bcd(m_val)) >> (4*k)) & 15;
                if (px >= x0 && px < x0 + 16 && !(m_warn && !ph) && glyph_on(g, px - x0, py - 8)) dig = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                x0 = 608 - 24*k;
                g = (k == 2) ? 15 : ((int'(level_num) >> (4*k)) & 15);
                if (px >= x0 && px < x0 + 16 && glyph_on(g, px - x0, py - 8)) dig = 1'b1;
            end
        end
        if (heart) return {1'b1, 8'hE0};
        if (dig)   return {1'b1, 8'hFF};
        return {1'b1, 8'h49};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        logic [8:0] ep;
        int         nv, ns, h;
        bit         noot;
        bit [2:0]   nlost;
        int         nleft;
        // hearts / loss animation
        h = (int'(num_of_hearts) > 3) ? 3 : int'(num_of_hearts);
        nlost = m_lost;
        nleft = m_left;
        if (h < m_prevh) begin
            for (int s = h; s < m_prevh; s++) nlost[s] = 1'b1;
            nleft = 60;
        end else if (startOfFrame && ((m_lost >> h) != 0)) begin
            nleft = m_left - 1;
            if (nleft == 0) nlost = '0;
        end
        for (int s = 0; s < h; s++) nlost[s] = 1'b0;
        ep = model_pixel(int'(pixelX), int'(pixelY), h, nlost);
        // timer
        nv = m_val;
        ns = m_st;
        noot = m_oot;
        if (timer_load) begin
            nv = bcd2int(load_value);
            noot = 1'b0;
            ns = (nv == 0) ? S_EXP : (pause ? S_PAU : S_RUN);
        end else begin
            if (m_st == S_RUN || m_st == S_PAU) ns = pause ? S_PAU : S_RUN;
            if (add_valid && (m_st == S_RUN || m_st == S_PAU)) begin
                nv = m_val + bcd2int(add_value);
                if (nv > 99) nv = 99;
            end else if (sec_tick && m_st == S_RUN) begin
                nv = m_val - 1;
                if (nv == 0) begin
                    ns = S_EXP;
                    noot = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_val = nv;
        m_st = ns;
        m_oot = noot;
        m_warn = (ns == S_RUN || ns == S_PAU) && nv <= 5;
        m_lost = nlost;
        m_left = nleft;
        m_prevh = h;
        if (startOfFrame) m_frames++;
        chk("timer", 32'(timer), 32'(int2bcd(m_val)));
        chk("timer_running", 32'(timer_running), 32'(m_st == S_RUN));
        chk("out_of_time", 32'(out_of_time), 32'(m_oot));
        chk("warn", 32'(warn), 32'(m_warn));
        chk("req", 32'(barDrawingRequest), 32'(ep[8]));
        chk("rgb", 32'(barRGB), 32'(ep[7:0]));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
            step();
            step();
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            step();
            sec_tick = 1'b0;
            step();
        end
    endtask

    task automatic load(input logic [7:0] v);
        timer_load = 1'b1;
        load_value = v;
        step();
        timer_load = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #2;
        chk("rst_timer", 32'(timer), 32'h0);
        chk("rst_running", 32'(timer_running), 32'h0);
        chk("rst_oot", 32'(out_of_time), 32'h0);
        chk("rst_warn", 32'(warn), 32'h0);
        chk("rst_req", 32'(barDrawingRequest), 32'h0);
        chk("rst_rgb", 32'(barRGB), 32'h0);
        m_val = 0; m_st = S_IDLE; m_oot = 1'b0; m_warn = 1'b0;
        m_frames = 0; m_prevh = 0; m_left = 0; m_lost = '0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();
        step();

        // countdown 12 -> 00 and expiry
        load(8'h12);
        chk("load12", 32'(timer), 32'h12);
        tick(12);
        chk("cd_end_timer", 32'(timer), 32'h00);
        chk("cd_end_oot", 32'(out_of_time), 32'h1);
        chk("cd_end_running", 32'(timer_running), 32'h0);

        // pause holds the count
        pause = 1'b1;
        load(8'h10);
        tick(3);
        chk("pause_hold", 32'(timer), 32'h10);
        pause = 1'b0;
        step();
        tick(1);
        chk("after_pause", 32'(timer), 32'h09);

        // saturating add drops the same-cycle tick
        load(8'h95);
        add_valid = 1'b1; add_value = 8'h07; sec_tick = 1'b1;
        step();
        add_valid = 1'b0; sec_tick = 1'b0;
        chk("add_sat", 32'(timer), 32'h99);
        load(8'h01);
        tick(1);
        chk("expire_oot", 32'(out_of_time), 32'h1);
        load(8'h30);
        chk("reload_oot", 32'(out_of_time), 32'h0);

        // low-time warning and digit blink at (325,20)
        load(8'h05);
        pixelX = 11'd325; pixelY = 11'd20;
        step();
        chk("warn_on", 32'(warn), 32'h1);
        chk("blink_vis", 32'(barRGB), 32'hFF);
        frames(15);
        step();
        chk("blink_off", 32'(barRGB), 32'h49);
        frames(15);
        step();
        chk("blink_vis2", 32'(barRGB), 32'hFF);
        frames(34);

        // heart loss 3 -> 1 on slot 1
        pixelX = 11'd70; pixelY = 11'd10;
        step();
        chk("heart1_on", 32'(barRGB), 32'hE0);
        num_of_hearts = 2'd1;
        step();
        frames(59);
        step();
        chk("loss_blink", 32'(barRGB), 32'hE0);
        frames(1);
        step();
        chk("loss_gone", 32'(barRGB), 32'h49);
        pixelX = 11'd16; pixelY = 11'd8;
        step();
        chk("heart0_rgb", 32'(barRGB), 32'hE0);

        // band edges
        pixelX = 11'd700; pixelY = 11'd20;
        step();
        chk("outx_req", 32'(barDrawingRequest), 32'h0);
        chk("outx_rgb", 32'(barRGB), 32'h0);
        pixelX = 11'd100; pixelY = 11'd60;
        step();
        chk("outy_req", 32'(barDrawingRequest), 32'h0);
        pixelX = 11'd200; pixelY = 11'd40;
        step();
        chk("bg_req", 32'(barDrawingRequest), 32'h1);
        chk("bg_rgb", 32'(barRGB), 32'h49);

        // union restart, re-activation, then reset mid-animation
        pixelX = 11'd120; pixelY = 11'd20;
        num_of_hearts = 2'd3; step();
        num_of_hearts = 2'd2; step();
        frames(5);
        num_of_hearts = 2'd0; step();
        frames(3);
        num_of_hearts = 2'd2; step();
        frames(4);
        do_reset();
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            timer_load = ($urandom_range(0, 63) == 0);
            load_value = int2bcd(($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 99));
            add_valid = ($urandom_range(0, 15) == 0);
            add_value = int2bcd($urandom_range(0, 99));
            sec_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) pause = ~pause;
            startOfFrame = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) num_of_hearts = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) level_num = int2bcd($urandom_range(0, 99));
            pixelX = 11'($urandom_range(0, 700));
            pixelY = 11'($urandom_range(0, 60));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
